// File: rtl/sf2_led_ctrl_pkg.sv
// Shared types, opcodes and LED pattern helper for the Kickstart LED controller.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
// Optional feature macro: SF2_LED_CTRL_PWM_EN (adds the SET_BRIGHT opcode).
package sf2_led_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_COUNT  = 2'd1,
    MODE_MANUAL = 2'd2,
    MODE_FLASH  = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARG  = 2'd1,
    ST_EXEC = 2'd2
  } state_t;

  localparam logic [7:0] OPC_SET_MODE   = 8'h01;
  localparam logic [7:0] OPC_SET_GREEN  = 8'h02;
  localparam logic [7:0] OPC_SET_RED    = 8'h03;
  localparam logic [7:0] OPC_SET_BRIGHT = 8'h04;

  typedef struct packed {
    logic [3:0] g;
    logic [3:0] r;
  } led_pair_t;

  // True when the opcode changes state; anything else raises cmd_err.
  function automatic logic opc_known(input logic [7:0] opc);
`ifdef SF2_LED_CTRL_PWM_EN
    return (opc == OPC_SET_MODE) || (opc == OPC_SET_GREEN) ||
           (opc == OPC_SET_RED)  || (opc == OPC_SET_BRIGHT);
`else
    return (opc == OPC_SET_MODE) || (opc == OPC_SET_GREEN) ||
           (opc == OPC_SET_RED);
`endif
  endfunction

  // Ungated LED pattern for a mode. Red wins on a bi-color LED, so green is
  // masked wherever red is lit.
  function automatic led_pair_t led_pattern(input mode_t      m,
                                            input logic [3:0] grn,
                                            input logic [3:0] red,
                                            input logic [4:0] step);
    led_pair_t p;
    p = '0;
    case (m)
      MODE_OFF: p = '0;
      MODE_COUNT: begin
        if (step[4]) p.r = step[3:0];
        else         p.g = step[3:0];
      end
      MODE_MANUAL: begin
        p.r = red;
        p.g = grn & ~red;
      end
      MODE_FLASH: begin
        if (step[0]) begin
          p.r = red;
          p.g = grn & ~red;
        end
      end
      default: p = '0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/sf2_led_ctrl_tick.sv
// Step timer: prescaler wrapping every STEP_CYCLES clocks, 5-bit step counter.
// Latency: step changes on the edge where the prescaler wraps; clear takes effect next edge.
// Backpressure: none; free-running while enable_i is high, clear_i overrides a tick.
// Ports: clk_i, rst_ni (async active-low), clear_i, enable_i -> tick_o (1-cycle), step_o[4:0].
module sf2_led_tick
  #(parameter int STEP_CYCLES = 10)
  (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clear_i,
    input  logic       enable_i,
    output logic       tick_o,
    output logic [4:0] step_o
  );

  localparam int CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STEP_CYCLES - 1);

  logic [CNT_W-1:0] presc_q, presc_d;
  logic [4:0]       step_q, step_d;

  assign tick_o = enable_i && (presc_q == CNT_MAX);
  assign step_o = step_q;

  always_comb begin
    presc_d = presc_q;
    step_d  = step_q;
    if (clear_i) begin
      presc_d = '0;
      step_d  = '0;
    end else if (enable_i) begin
      if (tick_o) begin
        presc_d = '0;
        step_d  = step_q + 5'd1;   // wraps 31 -> 0
      end else begin
        presc_d = presc_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_q <= '0;
      step_q  <= '0;
    end else begin
      presc_q <= presc_d;
      step_q  <= step_d;
    end
  end

endmodule

// File: rtl/sf2_led_ctrl.sv
// Byte-command LED controller for the SmartFusion2 Kickstart bi-color LEDs.
// Latency: arg byte accepted on edge N -> config updates at N+1 -> led_* change at N+2.
// Backpressure: cmd_ready drops for the single EXEC cycle of each command; source holds the byte.
// Ports: clk_50mhz, rst_n (async active-low), cmd_valid/cmd_data[7:0]/cmd_ready byte stream,
//        cmd_err pulse, mode[1:0], led_g[3:0], led_r[3:0].
// Optional feature macro: SF2_LED_CTRL_PWM_EN (SET_BRIGHT opcode + 16-level PWM gating).
module sf2_led_ctrl
  import sf2_led_ctrl_pkg::*;
  #(parameter real CLK_FREQUENCY = 50.0e6,
    parameter real STEP_PERIOD   = 0.125)
  (
    input  logic       clk_50mhz,
    input  logic       rst_n,
    input  logic       cmd_valid,
    input  logic [7:0] cmd_data,
    output logic       cmd_ready,
    output logic       cmd_err,
    output logic [1:0] mode,
    output logic [3:0] led_g,
    output logic [3:0] led_r
  );

  localparam int STEP_CYCLES = integer'(CLK_FREQUENCY * STEP_PERIOD);

  state_t     state_q, state_d;
  logic       cmd_ready_q, cmd_ready_d;
  logic       cmd_err_q, cmd_err_d;
  logic [7:0] opc_q, opc_d;
  logic [3:0] arg_q, arg_d;        // only the low nibble of any arg is ever used
  mode_t      mode_q, mode_d;
  logic [3:0] green_q, green_d;
  logic [3:0] red_q, red_d;
  logic [3:0] led_g_q, led_g_d;
  logic [3:0] led_r_q, led_r_d;

  logic       accept;
  logic       step_clr;
  logic [4:0] step;
  logic       tick_unused;         // step alone carries all display timing here
  logic       pwm_on;
  led_pair_t  pat;

  assign accept   = cmd_valid && cmd_ready_q;
  assign step_clr = (state_q == ST_EXEC) && (opc_q == OPC_SET_MODE);

  sf2_led_tick #(.STEP_CYCLES(STEP_CYCLES)) u_tick (
    .clk_i    (clk_50mhz),
    .rst_ni   (rst_n),
    .clear_i  (step_clr),
    .enable_i (1'b1),
    .tick_o   (tick_unused),
    .step_o   (step)
  );

`ifdef SF2_LED_CTRL_PWM_EN
  logic [3:0] bright_q, bright_d;
  logic [3:0] pwm_q;

  assign pwm_on = (bright_q == 4'hF) || (pwm_q < bright_q);

  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      bright_q <= 4'hF;
      pwm_q    <= '0;
    end else begin
      bright_q <= bright_d;
      pwm_q    <= pwm_q + 4'd1;
    end
  end
`else
  assign pwm_on = 1'b1;
`endif

  // Command FSM and config update.
  always_comb begin
    state_d   = state_q;
    opc_d     = opc_q;
    arg_d     = arg_q;
    cmd_err_d = 1'b0;
    mode_d    = mode_q;
    green_d   = green_q;
    red_d     = red_q;
`ifdef SF2_LED_CTRL_PWM_EN
    bright_d  = bright_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          opc_d   = cmd_data;
          state_d = ST_ARG;
        end
      end
      ST_ARG: begin
        if (accept) begin
          arg_d     = cmd_data[3:0];
          state_d   = ST_EXEC;
          // Registered so the pulse lines up exactly with the EXEC cycle.
          cmd_err_d = !opc_known(opc_q);
        end
      end
      ST_EXEC: begin
        state_d = ST_IDLE;
        case (opc_q)
          OPC_SET_MODE:  mode_d  = mode_t'(arg_q[1:0]);
          OPC_SET_GREEN: green_d = arg_q;
          OPC_SET_RED:   red_d   = arg_q;
`ifdef SF2_LED_CTRL_PWM_EN
          OPC_SET_BRIGHT: bright_d = arg_q;
`endif
          default: ;
        endcase
      end
      default: state_d = ST_IDLE;
    endcase
    cmd_ready_d = (state_d != ST_EXEC);
  end

  // LEDs follow the current config one edge later.
  always_comb begin
    pat     = led_pattern(mode_q, green_q, red_q, step);
    led_g_d = pat.g & {4{pwm_on}};
    led_r_d = pat.r & {4{pwm_on}};
  end

  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b0;
      cmd_err_q   <= 1'b0;
      opc_q       <= '0;
      arg_q       <= '0;
      mode_q      <= MODE_COUNT;
      green_q     <= '0;
      red_q       <= '0;
      led_g_q     <= '0;
      led_r_q     <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      cmd_err_q   <= cmd_err_d;
      opc_q       <= opc_d;
      arg_q       <= arg_d;
      mode_q      <= mode_d;
      green_q     <= green_d;
      red_q       <= red_d;
      led_g_q     <= led_g_d;
      led_r_q     <= led_r_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign cmd_err   = cmd_err_q;
  assign mode      = mode_q;
  assign led_g     = led_g_q;
  assign led_r     = led_r_q;

endmodule

// File: tb/tb_sf2_led_ctrl.sv
// Self-checking bench for sf2_led_ctrl with a cycle-level reference model.
module tb_sf2_led_ctrl;

  localparam int SC = 10;

  logic       clk_50mhz = 1'b0;
  logic       rst_n     = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_data  = 8'h00;
  logic       cmd_ready, cmd_err;
  logic [1:0] mode;
  logic [3:0] led_g, led_r;

  int checks = 0;
  int failures = 0;
  bit chk_on = 0;
  int err_seen = 0;

  always #5 clk_50mhz = ~clk_50mhz;

  sf2_led_ctrl #(.CLK_FREQUENCY(50.0e6), .STEP_PERIOD(2.0e-7)) dut (
    .clk_50mhz (clk_50mhz),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_data  (cmd_data),
    .cmd_ready (cmd_ready),
    .cmd_err   (cmd_err),
    .mode      (mode),
    .led_g     (led_g),
    .led_r     (led_r)
  );

  // ---------------- reference model ----------------
  int m_bytes, m_opc, m_arg, m_mode, m_g, m_r, m_t;
  int m_led_g, m_led_r, m_rdy, m_err, m_pwm, m_bright;
  int md_step, md_g, md_r;
  bit md_acc;

  function automatic bit known_op(input int op);
`ifdef SF2_LED_CTRL_PWM_EN
    return op >= 1 && op <= 4;
`else
    return op >= 1 && op <= 3;
`endif
  endfunction

  function automatic int pat_g(input int md, input int g, input int r, input int s);
    case (md)
      1:       return (s < 16) ? s : 0;
      2:       return g & ~r & 15;
      3:       return (s % 2 == 1) ? (g & ~r & 15) : 0;
      default: return 0;
    endcase
  endfunction

  function automatic int pat_r(input int md, input int r, input int s);
    case (md)
      1:       return (s >= 16) ? s - 16 : 0;
      2:       return r;
      3:       return (s % 2 == 1) ? r : 0;
      default: return 0;
    endcase
  endfunction

  always @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      m_bytes = 0; m_opc = 0; m_arg = 0; m_mode = 1; m_g = 0; m_r = 0; m_t = 0;
      m_led_g = 0; m_led_r = 0; m_rdy = 0; m_err = 0; m_pwm = 0; m_bright = 15;
    end else begin
      md_step = (m_t / SC) % 32;
      md_g = pat_g(m_mode, m_g, m_r, md_step);
      md_r = pat_r(m_mode, m_r, md_step);
      if (!(m_bright == 15 || m_pwm < m_bright)) begin md_g = 0; md_r = 0; end
      m_led_g = md_g;
      m_led_r = md_r;
      m_pwm = (m_pwm + 1) % 16;
      md_acc = cmd_valid && (m_rdy != 0);
      m_err = 0;
      m_t = m_t + 1;
      if (m_bytes == 2) begin
        case (m_opc)
          1: begin m_mode = m_arg % 4; m_t = 0; end
          2: m_g = m_arg % 16;
          3: m_r = m_arg % 16;
`ifdef SF2_LED_CTRL_PWM_EN
          4: m_bright = m_arg % 16;
`endif
          default: ;
        endcase
        m_bytes = 0;
      end else if (md_acc && m_bytes == 1) begin
        m_arg = int'(cmd_data);
        m_bytes = 2;
        m_err = known_op(m_opc) ? 0 : 1;
      end else if (md_acc) begin
        m_opc = int'(cmd_data);
        m_bytes = 1;
      end
      m_rdy = (m_bytes != 2) ? 1 : 0;
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk_50mhz) begin
    if (chk_on) begin
      chk("mode", int'(mode), m_mode);
      chk("led_g", int'(led_g), m_led_g);
      chk("led_r", int'(led_r), m_led_r);
      chk("cmd_ready", int'(cmd_ready), m_rdy);
      chk("cmd_err", int'(cmd_err), m_err);
    end
    if (cmd_err) err_seen++;
  end

  // ---------------- stimulus helpers (called at a negedge) ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk_50mhz);
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_data  = b;
    while (!cmd_ready && n < 50) begin
      @(negedge clk_50mhz);
      n++;
    end
    if (n >= 50) begin
      checks++;
      failures++;
      $display("FAIL handshake: cmd_ready stuck at %0d, required 1", cmd_ready);
    end
    @(negedge clk_50mhz);           // accepting edge lies in between
    cmd_valid = 1'b0;
    cmd_data  = 8'($urandom);
  endtask

  task automatic send_cmd(input logic [7:0] op, input logic [7:0] arg, input int gap);
    cycles(gap);
    send(op);
    cycles(gap);
    send(arg);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, cnt, r;
    logic [7:0] op;

    // ---- 1: reset, free-running COUNT mode ----
    #2 rst_n = 1'b0;
    #1 chk_on = 1;
    cycles(3);
    chk("lit_rst_ready", int'(cmd_ready), 0);
    chk("lit_rst_mode", int'(mode), 1);
    chk("lit_rst_led", int'({led_g, led_r}), 0);
    rst_n = 1'b1;                      // released at a negedge
    cycles(1);
    chk("lit_ready_after_rst", int'(cmd_ready), 1);
    cycles(55);                        // after edge 56: step 5
    chk("lit_step5_g", int'(led_g), 5);
    chk("lit_step5_r", int'(led_r), 0);
    cycles(109);                       // edge 165: step 16
    chk("lit_step16_g", int'(led_g), 0);
    chk("lit_step16_r", int'(led_r), 0);
    cycles(30);                        // edge 195: step 19
    chk("lit_step19_r", int'(led_r), 3);
    cycles(120);                       // edge 315: step 31
    chk("lit_step31_r", int'(led_r), 15);
    cycles(6);                         // edge 321: wrapped to step 0
    chk("lit_wrap_g", int'(led_g), 0);
    chk("lit_wrap_r", int'(led_r), 0);

    // ---- 2: MANUAL, latency of SET_RED ----
    send_cmd(8'h01, 8'h02, 0);
    send_cmd(8'h02, 8'h0F, 1);
    send_cmd(8'h03, 8'h05, 0);         // now after arg accept edge N
    cycles(1);
    chk("lit_red_N1", int'(led_r), 0);
    cycles(1);
    chk("lit_red_N2", int'(led_r), 5);
    chk("lit_green_N2", int'(led_g), 10);
    chk("lit_manual_mode", int'(mode), 2);

    // ---- 3: FLASH with green=9 ----
    send_cmd(8'h02, 8'h09, 0);
    send_cmd(8'h03, 8'h00, 0);
    send_cmd(8'h01, 8'h03, 0);
    cycles(2);
    chk("lit_flash_off", int'(led_g), 0);
    cycles(9);
    chk("lit_flash_off_end", int'(led_g), 0);
    cycles(1);
    chk("lit_flash_on", int'(led_g), 9);
    cycles(10);
    chk("lit_flash_off2", int'(led_g), 0);

    // ---- 4: unknown opcode ----
    e0 = err_seen;
    send_cmd(8'h7E, 8'h33, 0);
    cycles(3);
    chk("lit_err_pulses", err_seen - e0, 1);
    chk("lit_err_mode", int'(mode), 3);
    send_cmd(8'h01, 8'h02, 0);
    cycles(2);
    chk("lit_after_err_mode", int'(mode), 2);
    chk("lit_after_err_g", int'(led_g), 9);

    // ---- 5: reset mid-command ----
    send(8'h02);
    rst_n = 1'b0;
    cycles(2);
    chk("lit_mid_rst_led", int'({led_g, led_r}), 0);
    chk("lit_mid_rst_ready", int'(cmd_ready), 0);
    chk("lit_mid_rst_mode", int'(mode), 1);
    rst_n = 1'b1;
    cycles(1);
    send_cmd(8'h01, 8'h00, 0);
    cycles(2);
    chk("lit_post_rst_mode", int'(mode), 0);
    chk("lit_post_rst_led", int'({led_g, led_r}), 0);

    // ---- 6: brightness ----
`ifdef SF2_LED_CTRL_PWM_EN
    send_cmd(8'h01, 8'h02, 0);
    send_cmd(8'h02, 8'h0F, 0);
    send_cmd(8'h04, 8'h04, 0);
    cycles(3);
    cnt = 0;
    for (int i = 0; i < 32; i++) begin
      cycles(1);
      if (led_g == 4'hF) cnt++;
    end
    chk("lit_pwm_on_cycles", cnt, 8);
    send_cmd(8'h04, 8'h00, 0);
    cycles(3);
    cnt = 0;
    for (int i = 0; i < 32; i++) begin
      cycles(1);
      if (led_g != 4'h0) cnt++;
    end
    chk("lit_pwm_dark", cnt, 0);
`else
    e0 = err_seen;
    send_cmd(8'h04, 8'h04, 0);
    cycles(3);
    chk("lit_no_pwm_err", err_seen - e0, 1);
`endif

    // ---- random commands against the model ----
    for (int k = 0; k < 150; k++) begin
      r = $urandom_range(0, 9);
      if (r <= 2)      op = 8'h01;
      else if (r <= 5) op = 8'h02;
      else if (r <= 7) op = 8'h03;
      else if (r == 8) op = 8'($urandom);
      else             op = 8'h04;
      send_cmd(op, 8'($urandom), $urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) cycles($urandom_range(10, 60));
    end
    cycles(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
